// File: rtl/wf_iq_pkg.sv
// wf_iq_pkg: shared types, constants and helpers for the multi-channel waterfall IQ sampler
package wf_iq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2} state_t;
    localparam logic PH_I = 1'b0;
    localparam logic PH_Q = 1'b1;
    localparam int MAX_NCH = 8;
    localparam int MAX_DEPTH = 8192;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/wf_iq_sampler_multi_if.sv
// wf_iq_sampler_multi_if: write/control/readout bundle of the multi-channel IQ sampler
interface wf_iq_sampler_multi_if import wf_iq_pkg::*; #(
    parameter int NCH = 4,
    parameter int IQ_WIDTH = 16,
    parameter int DEPTH = 1024
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = (NCH > 1) ? clog2(NCH) : 1;
    logic                    wr_strobe;
    logic [NCH*IQ_WIDTH-1:0] wr_i;
    logic [NCH*IQ_WIDTH-1:0] wr_q;
    logic [NCH-1:0]          ch_en;
    logic                    arm;
    logic                    continuous;
    logic [CW-1:0]           rd_ch;
    logic                    rd_sync;
    logic                    rd_next;
    logic [IQ_WIDTH-1:0]     rd_data;
    logic                    full;
    logic                    capturing;
    logic                    overrun;
    logic [AW:0]             wr_count;
    modport master (
        output wr_strobe, wr_i, wr_q, ch_en, arm, continuous, rd_ch, rd_sync, rd_next,
        input  rd_data, full, capturing, overrun, wr_count
    );
    modport slave (
        input  wr_strobe, wr_i, wr_q, ch_en, arm, continuous, rd_ch, rd_sync, rd_next,
        output rd_data, full, capturing, overrun, wr_count
    );
endinterface

// File: rtl/wf_iq_sampler_multi_bank.sv
// wf_iq_bank: one channel's simple dual-port sample RAM with a registered, enabled read port
module wf_iq_bank import wf_iq_pkg::*; #(
    parameter int DW = 32,
    parameter int DEPTH = 1024,
    parameter int AW = clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    // Read register only updates on a read command so the output holds between commands
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/wf_iq_sampler_multi.sv
// wf_iq_sampler_multi: NCH-bank waterfall IQ capture (one-shot/ring) with sequential I/Q readout; WF_IQ_AVG2_EN averages strobe pairs
module wf_iq_sampler_multi import wf_iq_pkg::*; #(
    parameter int NCH = 4,
    parameter int IQ_WIDTH = 16,
    parameter int DEPTH = 1024
) (
    input logic adc_clk,
    input logic reset_n,
    wf_iq_sampler_multi_if.slave bus
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = (NCH > 1) ? clog2(NCH) : 1;
    localparam int DW = 2 * IQ_WIDTH;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   wr_count_q, wr_count_d;
    logic          full_q, full_d, overrun_q, overrun_d, cont_q, cont_d, phase_q, phase_d;
    logic [CW-1:0] rd_ch_q, rd_ch_d;
    logic          eff, wr_en, wrap, rd_cmd;
    logic [DW-1:0] wdata [NCH];
    logic [DW-1:0] rdata [NCH];

    // arm wins over a coincident strobe, so that sample never reaches the banks
    assign eff    = bus.wr_strobe && !bus.arm && (state_q == CAPTURE);
    assign wrap   = wr_en && (wr_ptr_q == LAST);
    assign rd_cmd = bus.rd_sync || bus.rd_next;

`ifdef WF_IQ_AVG2_EN
    logic pair_q, pair_d;
    assign wr_en  = eff && pair_q;
    assign pair_d = bus.arm ? 1'b0 : eff ? !pair_q : pair_q;
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) pair_q <= 1'b0;
        else pair_q <= pair_d;
    end
`else
    assign wr_en = eff;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [IQ_WIDTH-1:0] s_i, s_q;
        assign s_i = bus.wr_i[c*IQ_WIDTH +: IQ_WIDTH];
        assign s_q = bus.wr_q[c*IQ_WIDTH +: IQ_WIDTH];
`ifdef WF_IQ_AVG2_EN
        logic [DW-1:0] hold_q, hold_d;
        logic signed [IQ_WIDTH:0] sum_i, sum_q;
        assign hold_d = (eff && !pair_q) ? {s_i, s_q} : hold_q;
        always_ff @(posedge adc_clk or negedge reset_n) begin
            if (!reset_n) hold_q <= '0;
            else hold_q <= hold_d;
        end
        assign sum_i = {hold_q[DW-1], hold_q[DW-1 -: IQ_WIDTH]} + {s_i[IQ_WIDTH-1], s_i};
        assign sum_q = {hold_q[IQ_WIDTH-1], hold_q[IQ_WIDTH-1:0]} + {s_q[IQ_WIDTH-1], s_q};
        assign wdata[c] = {IQ_WIDTH'(sum_i >>> 1), IQ_WIDTH'(sum_q >>> 1)};
`else
        assign wdata[c] = {s_i, s_q};
`endif
        wf_iq_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank (
            .clk_i   (adc_clk),
            .rst_ni  (reset_n),
            .we_i    (wr_en && bus.ch_en[c]),
            .waddr_i (wr_ptr_q),
            .wdata_i (wdata[c]),
            .re_i    (rd_cmd),
            .raddr_i (rd_ptr_d),
            .rdata_o (rdata[c])
        );
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = bus.arm ? CAPTURE : (wrap && !cont_q) ? DONE : state_q;
    end

    always_comb begin
        bus.capturing = (state_q == CAPTURE);
    end

    always_comb begin
        wr_ptr_d   = bus.arm ? '0 : wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        wr_count_d = bus.arm ? '0 : (wr_en && wr_count_q != FULL_CNT) ? wr_count_q + (AW + 1)'(1) : wr_count_q;
        full_d     = bus.arm ? 1'b0 : full_q || wrap;
        overrun_d  = bus.arm ? 1'b0 : overrun_q || (bus.wr_strobe && state_q == DONE);
        cont_d     = bus.arm ? bus.continuous : cont_q;
        rd_ch_d    = bus.rd_sync ? bus.rd_ch : rd_ch_q;
        rd_ptr_d   = bus.rd_sync ? ((cont_q && full_q) ? wr_ptr_q : '0) :
                     (bus.rd_next && phase_q == PH_Q) ? rd_ptr_q + AW'(1) : rd_ptr_q;
        phase_d    = bus.rd_sync ? PH_I : bus.rd_next ? ~phase_q : phase_q;
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            wr_count_q <= '0;
            full_q     <= 1'b0;
            overrun_q  <= 1'b0;
            cont_q     <= 1'b0;
            rd_ch_q    <= '0;
            rd_ptr_q   <= '0;
            phase_q    <= PH_I;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            wr_count_q <= wr_count_d;
            full_q     <= full_d;
            overrun_q  <= overrun_d;
            cont_q     <= cont_d;
            rd_ch_q    <= rd_ch_d;
            rd_ptr_q   <= rd_ptr_d;
            phase_q    <= phase_d;
        end
    end

    assign bus.full     = full_q;
    assign bus.overrun  = overrun_q;
    assign bus.wr_count = wr_count_q;
    assign bus.rd_data  = (phase_q == PH_I) ? rdata[rd_ch_q][DW-1 -: IQ_WIDTH] : rdata[rd_ch_q][IQ_WIDTH-1:0];
endmodule

// File: tb/tb_wf_iq_sampler_multi.sv
// tb_wf_iq_sampler_multi: directed checks of capture modes, channel enables, arm priority and readout (NCH=4, DEPTH=16)
module tb_wf_iq_sampler_multi;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    wf_iq_sampler_multi_if #(.NCH(4), .IQ_WIDTH(16), .DEPTH(16)) bus ();

    wf_iq_sampler_multi #(.NCH(4), .IQ_WIDTH(16), .DEPTH(16)) dut (
        .adc_clk (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Channel c carries n + 256*c on I and its negation on Q so bank-select faults show up
    function automatic logic [15:0] iv(input int c, input int n);
        return 16'(n + c * 256);
    endfunction

    function automatic logic [15:0] qv(input int c, input int n);
        return 16'(-(n + c * 256));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int n);
        for (int c = 0; c < 4; c++) begin
            bus.wr_i[c*16 +: 16] = iv(c, n);
            bus.wr_q[c*16 +: 16] = qv(c, n);
        end
    endtask

    task automatic do_strobe(input int n, input logic [3:0] en);
        set_data(n);
        bus.ch_en = en;
        bus.wr_strobe = 1'b1;
        tick();
        bus.wr_strobe = 1'b0;
    endtask

    task automatic do_arm(input logic cont, input logic with_strobe, input int n);
        set_data(n);
        bus.continuous = cont;
        bus.arm = 1'b1;
        bus.wr_strobe = with_strobe;
        tick();
        bus.arm = 1'b0;
        bus.wr_strobe = 1'b0;
    endtask

    task automatic cmd_sync(input int ch);
        bus.rd_ch = 2'(ch);
        bus.rd_sync = 1'b1;
        tick();
        bus.rd_sync = 1'b0;
    endtask

    task automatic cmd_next();
        bus.rd_next = 1'b1;
        tick();
        bus.rd_next = 1'b0;
    endtask

    initial begin
        bus.wr_strobe = 1'b0;
        bus.wr_i = '0;
        bus.wr_q = '0;
        bus.ch_en = '0;
        bus.arm = 1'b0;
        bus.continuous = 1'b0;
        bus.rd_ch = '0;
        bus.rd_sync = 1'b0;
        bus.rd_next = 1'b0;
        tick();
        tick();
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_full", bus.full, 0);
        check("rst_capturing", bus.capturing, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_wr_count", bus.wr_count, 0);
        reset_n = 1'b1;
        tick();
        do_strobe(55, 4'hf);
        check("idle_strobe_count", bus.wr_count, 0);
        check("idle_strobe_overrun", bus.overrun, 0);
`ifdef WF_IQ_AVG2_EN
        do_arm(1'b0, 1'b0, 0);
        do_strobe(3, 4'hf);
        check("avg_count_half", bus.wr_count, 0);
        do_strobe(5, 4'hf);
        check("avg_count_1", bus.wr_count, 1);
        do_strobe(-4, 4'hf);
        do_strobe(-7, 4'hf);
        check("avg_count_2", bus.wr_count, 2);
        do_strobe(9, 4'hf);
        check("avg_odd_trailing", bus.wr_count, 2);
        cmd_sync(1);
        check("avg_i0", bus.rd_data, iv(1, 4));
        cmd_next();
        check("avg_q0", bus.rd_data, qv(1, 4));
        cmd_next();
        check("avg_i1", bus.rd_data, iv(1, -6));
        cmd_next();
        check("avg_q1", bus.rd_data, qv(1, -5));
        do_arm(1'b0, 1'b0, 0);
        do_strobe(10, 4'hf);
        do_strobe(20, 4'hf);
        check("avg_rearm_count", bus.wr_count, 1);
        cmd_sync(3);
        check("avg_rearm_i0", bus.rd_data, iv(3, 15));
`else
        // One-shot capture of 16 samples followed by 4 strobes in DONE
        do_arm(1'b0, 1'b0, 0);
        check("os_capturing", bus.capturing, 1);
        check("os_count0", bus.wr_count, 0);
        for (int n = 0; n < 15; n++) do_strobe(n, 4'hf);
        check("os_count15", bus.wr_count, 15);
        check("os_full15", bus.full, 0);
        do_strobe(15, 4'hf);
        check("os_full16", bus.full, 1);
        check("os_done", bus.capturing, 0);
        check("os_count16", bus.wr_count, 16);
        check("os_no_overrun16", bus.overrun, 0);
        do_strobe(16, 4'hf);
        check("os_overrun17", bus.overrun, 1);
        check("os_count17", bus.wr_count, 16);
        for (int n = 17; n < 20; n++) do_strobe(n, 4'hf);
        cmd_sync(2);
        for (int k = 0; k < 16; k++) begin
            check("os_rd_i", bus.rd_data, iv(2, k));
            cmd_next();
            check("os_rd_q", bus.rd_data, qv(2, k));
            cmd_next();
        end
        check("os_rd_wrap", bus.rd_data, iv(2, 0));
        // Continuous capture of 21 samples: ring wraps, oldest sample is n=5
        do_arm(1'b1, 1'b0, 0);
        check("ring_overrun_clr", bus.overrun, 0);
        check("ring_full_clr", bus.full, 0);
        for (int n = 0; n < 16; n++) do_strobe(n, 4'hf);
        check("ring_full16", bus.full, 1);
        check("ring_capturing16", bus.capturing, 1);
        for (int n = 16; n < 21; n++) do_strobe(n, 4'hf);
        check("ring_count", bus.wr_count, 16);
        check("ring_capturing", bus.capturing, 1);
        check("ring_full", bus.full, 1);
        check("ring_overrun", bus.overrun, 0);
        cmd_sync(1);
        check("ring_rd_i5", bus.rd_data, iv(1, 5));
        cmd_next();
        check("ring_rd_q5", bus.rd_data, qv(1, 5));
        cmd_next();
        check("ring_rd_i6", bus.rd_data, iv(1, 6));
        // Second one-shot capture with only banks 0 and 2 enabled
        do_arm(1'b0, 1'b0, 0);
        for (int n = 100; n < 116; n++) do_strobe(n, 4'b0101);
        check("en_full", bus.full, 1);
        cmd_sync(0);
        check("en_ch0_new", bus.rd_data, iv(0, 100));
        cmd_sync(1);
        check("en_ch1_old", bus.rd_data, iv(1, 16));
        cmd_sync(2);
        check("en_ch2_new", bus.rd_data, iv(2, 100));
        cmd_sync(3);
        check("en_ch3_old_i", bus.rd_data, iv(3, 16));
        cmd_next();
        check("en_ch3_old_q", bus.rd_data, qv(3, 16));
        cmd_next();
        check("en_ch3_old_i1", bus.rd_data, iv(3, 17));
        // Arm coinciding with a strobe, from DONE and then mid-capture
        do_strobe(500, 4'hf);
        check("done_overrun", bus.overrun, 1);
        do_arm(1'b1, 1'b1, 999);
        check("armdone_overrun", bus.overrun, 0);
        check("armdone_count", bus.wr_count, 0);
        check("armdone_capturing", bus.capturing, 1);
        for (int n = 300; n < 318; n++) do_strobe(n, 4'hf);
        check("mid_full", bus.full, 1);
        check("mid_count", bus.wr_count, 16);
        do_arm(1'b0, 1'b1, 777);
        check("armmid_count", bus.wr_count, 0);
        check("armmid_full", bus.full, 0);
        check("armmid_overrun", bus.overrun, 0);
        do_strobe(400, 4'hf);
        do_strobe(401, 4'hf);
        check("armmid_count2", bus.wr_count, 2);
        check("armmid_capturing", bus.capturing, 1);
        cmd_sync(0);
        check("armmid_i0", bus.rd_data, iv(0, 400));
        cmd_next();
        cmd_next();
        check("armmid_i1", bus.rd_data, iv(0, 401));
        cmd_next();
        cmd_next();
        check("armmid_absent", bus.rd_data, iv(0, 302));
        // rd_sync and rd_next together: sync wins, then the word holds
        bus.rd_ch = 2'd0;
        bus.rd_sync = 1'b1;
        bus.rd_next = 1'b1;
        tick();
        bus.rd_sync = 1'b0;
        bus.rd_next = 1'b0;
        check("syncnext_i0", bus.rd_data, iv(0, 400));
        tick();
        tick();
        check("rd_hold", bus.rd_data, iv(0, 400));
        cmd_next();
        check("syncnext_q0", bus.rd_data, qv(0, 400));
`endif
        // Reset mid-capture returns everything to reset values
        do_arm(1'b1, 1'b0, 0);
        do_strobe(1, 4'hf);
        reset_n = 1'b0;
        #1;
        check("areset_capturing", bus.capturing, 0);
        check("areset_count", bus.wr_count, 0);
        check("areset_rd_data", bus.rd_data, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/wf_iq_sampler_multi.md
Name: wf_iq_sampler_multi

Overview:
- Multi-channel waterfall IQ capture buffer: successor to the single-channel 8K IQ sampler.
- Stores NCH time-aligned decimated IQ streams (one per waterfall CIC pair) into per-channel banks.
- Supports one-shot and continuous (ring) capture, plus a sequential I/Q readout port.
- Sits after the waterfall CICs, entirely in the adc_clk domain; CPU-side command pulses arrive already synchronised.

Parameters:
- NCH, 4: number of channels (1..8).
- IQ_WIDTH, 16: bit width of each I or Q sample.
- DEPTH, 1024: samples per channel; power of two, 16..8192.
- AW, clog2(DEPTH): address width (derived; do not override).

Ports:
- adc_clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_strobe  in  1  one aligned sample present on all channels.
- wr_i  in  NCH*IQ_WIDTH  I samples, channel c at [c*IQ_WIDTH +: IQ_WIDTH], signed.
- wr_q  in  NCH*IQ_WIDTH  Q samples, same packing.
- ch_en  in  NCH  per-channel write enable, sampled on every strobe.
- arm  in  1  pulse: start or restart a capture.
- continuous  in  1  mode, latched on arm: 1 = ring, 0 = one-shot.
- rd_ch  in  clog2(NCH) (min 1)  channel to read, latched on rd_sync.
- rd_sync  in  1  pulse: reset the read pointer.
- rd_next  in  1  pulse: advance the read stream.
- rd_data  out  IQ_WIDTH  current read word.
- full  out  1  one-shot done, or ring has wrapped at least once.
- capturing  out  1  state == CAPTURE.
- overrun  out  1  sticky: strobe arrived while DONE.
- wr_count  out  AW+1  samples written since arm, saturating at DEPTH.

Behaviour:
- Reset values: all outputs 0; state IDLE; wr_ptr 0; rd_ptr 0; rd_phase 0; latched mode 0.
- States and transitions:
  - IDLE -arm-> CAPTURE.
  - CAPTURE -arm-> CAPTURE: restart, with wr_ptr, wr_count, full and overrun cleared.
  - CAPTURE -(one-shot and DEPTHth write)-> DONE.
  - DONE -arm-> CAPTURE.
  - Continuous mode never enters DONE.
- Write path, in CAPTURE on each effective strobe:
  - Every channel with ch_en[c]=1 writes {I,Q} into bank c at wr_ptr.
  - wr_ptr then increments modulo DEPTH; wr_count increments, saturating at DEPTH.
  - Disabled banks keep their old contents.
- full:
  - One-shot: set on the cycle after the DEPTHth write.
  - Continuous: set when wr_ptr wraps from DEPTH-1 to 0.
- arm coinciding with wr_strobe: arm wins and the sample is discarded.
- Strobes in IDLE are ignored. Strobes in DONE are ignored and set overrun; overrun is cleared only by arm or reset.
- Read path, rd_sync:
  - Latches rd_ch.
  - Sets rd_ptr to wr_ptr (oldest sample) if latched continuous=1 and full=1; otherwise sets rd_ptr to 0.
  - Sets rd_phase = I.
- Read path, rd_next:
  - From phase I: switch to Q.
  - From phase Q: switch to I and rd_ptr+1 modulo DEPTH.
- rd_sync and rd_next in the same cycle: rd_sync wins.
- rd_data:
  - Valid 1 cycle after rd_sync or rd_next (registered RAM read).
  - Holds its value until the next read command.
  - Reading unwritten locations returns RAM contents; there is no error.
- Reading during continuous capture is permitted. The write pointer may overtake the read pointer; no protection is provided.
- Reset asserted mid-capture: immediate return to IDLE. RAM contents are undefined, outputs are at reset values.

Optional Feature:
- Macro: WF_IQ_AVG2_EN.
- Defined:
  - Each pair of effective strobes is averaged per channel: stored value = (a+b)>>>1, computed at IQ_WIDTH+1 bits then truncated.
  - The first strobe of a pair is held in a per-channel register; the write occurs on the second strobe.
  - wr_ptr, wr_count and full therefore advance at half the strobe rate.
  - arm clears the pair phase; an odd trailing sample is never written.
- Undefined: one write per strobe; no hold registers are instantiated.

Decomposition:
- Package wf_iq_pkg:
  - State encoding IDLE=0, CAPTURE=1, DONE=2.
  - Read-phase constants PH_I=0, PH_Q=1.
  - clog2 function.
  - Max NCH and DEPTH limits.
- Sub-module wf_iq_bank:
  - Simple dual-port RAM of DEPTH x 2*IQ_WIDTH, with one write port and a registered read port.
  - Instantiated NCH times.
  - Top-level read mux selects the bank and the I/Q half.

Test Plan:
- One-shot, NCH=4, DEPTH=16:
  - Stimulus: arm(continuous=0), 20 strobes with I=n, Q=-n, ch_en=4'b1111.
  - Response: full=1 after the 16th strobe; overrun=1 after the 17th; read ch2 after rd_sync returns 0,0,1,-1,...,15,-15.
- Continuous wrap:
  - Stimulus: 21 strobes into DEPTH=16, then rd_sync.
  - Response: first pair read is I=5,Q=-5; wr_count=16; capturing=1; full=1.
- ch_en=4'b0101 on a second capture:
  - Response: banks 1 and 3 still return the first capture's data; banks 0 and 2 return new data.
- arm coinciding with a strobe mid-capture:
  - Response: wr_count=0 the cycle after, that sample is absent, full and overrun are cleared.
- rd_sync and rd_next in the same cycle:
  - Response: rd_data = I of location 0, one cycle later.
- WF_IQ_AVG2_EN defined:
  - Stimulus: strobes I=3,5,-4,-7.
  - Response: stored 4, then -6 (from -11>>>1); wr_count=2.
